// File: rtl/ntt_addr_map.sv
// Conflict-free bank/row and twiddle address mapper for the NTT datapath,
// with a fixed-latency write-address delay line.
module ntt_addr_map #(
  parameter int WR_LAT = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ren,
  input  logic       sel,
  input  logic [7:0] k,
  input  logic [7:0] j,
  input  logic [2:0] p,
  output logic [1:0] rd_bank,
  output logic [5:0] rd_row,
  output logic [7:0] tw_addr,
  output logic       rd_valid,
  output logic [1:0] wr_bank,
  output logic [5:0] wr_row,
  output logic       wr_valid,
  output logic       p_err
);

  typedef struct packed {
    logic       v;
    logic [1:0] bank;
    logic [5:0] row;
  } wr_ent_t;

  logic        p_bad;
  logic [2:0]  pe;
  logic [3:0]  sh;
  logic [15:0] lin;
  logic [7:0]  idx;
  logic [15:0] rot;
  logic [7:0]  addr;
  logic [1:0]  nbank;
  logic [15:0] tws;
  logic [7:0]  tbase;
  logic [7:0]  ntw;

  wr_ent_t pipe [WR_LAT];

  always_comb begin
    p_bad = p > 3'd4;
    pe    = p_bad ? 3'd0 : p;
    sh    = {pe, 1'b0};
    lin   = {8'd0, k} << sh;
    idx   = lin[7:0] | j;
    // rotate by whole base-4 digits keeps the digit sum, hence the bank
    rot   = {idx, idx} << {pe[1:0], 1'b0};
    addr  = rot[15:8];
    nbank = addr[1:0] + addr[3:2]
          + addr[5:4] + addr[7:6];
    tws   = {8'd0, j} << (4'd8 - sh);
    tbase = (pe == 3'd0) ? 8'd0 : tws[7:0];
    ntw   = sel ? (8'd0 - tbase) : tbase;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_bank  <= '0;
      rd_row   <= '0;
      tw_addr  <= '0;
      p_err    <= 1'b0;
    end else begin
      rd_valid <= ren;
      if (ren) begin
        rd_bank <= nbank;
        rd_row  <= addr[7:2];
        tw_addr <= ntw;
        if (p_bad) p_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < WR_LAT; n++)
        pipe[n] <= '0;
    end else begin
      pipe[0] <= '{rd_valid, rd_bank, rd_row};
      for (int n = 1; n < WR_LAT; n++)
        pipe[n] <= pipe[n-1];
    end
  end

  assign wr_valid = pipe[WR_LAT-1].v;
  assign wr_bank  = pipe[WR_LAT-1].bank;
  assign wr_row   = pipe[WR_LAT-1].row;

endmodule

// File: tb/tb_ntt_addr_map.sv
// Randomized and directed checks of ntt_addr_map against an
// arithmetic reference model and a cycle-indexed history of reads.
module tb_ntt_addr_map;

  localparam int LAT = 13;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ren = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] k = '0;
  logic [7:0] j = '0;
  logic [2:0] p = '0;
  logic [1:0] rd_bank;
  logic [5:0] rd_row;
  logic [7:0] tw_addr;
  logic       rd_valid;
  logic [1:0] wr_bank;
  logic [5:0] wr_row;
  logic       wr_valid;
  logic       p_err;

  ntt_addr_map #(.WR_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .ren(ren), .sel(sel),
    .k(k), .j(j), .p(p),
    .rd_bank(rd_bank), .rd_row(rd_row),
    .tw_addr(tw_addr), .rd_valid(rd_valid),
    .wr_bank(wr_bank), .wr_row(wr_row),
    .wr_valid(wr_valid), .p_err(p_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int e_rv, e_rb, e_rr, e_tw, e_perr;
  int hist_v[$], hist_b[$], hist_r[$];

  bit sweep_on = 0;
  int cyc_no = 0;
  int wr_hi = 0;
  int rd_fall = -1000;
  int wr_fall = 0;
  bit prev_rv = 0;
  bit prev_wv = 0;
  int banks[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic void model(
    input int kk, input int jj, input int pp,
    input int ss, output int bank,
    output int row, output int tw);
    int pe, i, r, a, t;
    pe = (pp <= 4) ? pp : 0;
    i = ((kk * (1 << (2 * pe))) % 256) | jj;
    r = (2 * pe) % 8;
    a = ((i << r) | (i >> (8 - r))) % 256;
    bank = 0;
    for (int d = 0; d < 4; d++)
      bank += (a >> (2 * d)) % 4;
    bank = bank % 4;
    row = a / 4;
    t = (pe == 0) ? 0 :
        (jj * (1 << (8 - 2 * pe))) % 256;
    tw = ss ? (256 - t) % 256 : t;
  endfunction

  task automatic model_reset();
    e_rv = 0; e_rb = 0; e_rr = 0;
    e_tw = 0; e_perr = 0;
    hist_v.delete();
    hist_b.delete();
    hist_r.delete();
  endtask

  task automatic cyc();
    int nb, nr, nt, ev, eb, er, sz;
    bit take;
    take = ren;
    model(k, j, p, sel, nb, nr, nt);
    if (take && p > 4) e_perr = 1;
    @(posedge clk);
    #1;
    cyc_no++;
    e_rv = take;
    if (take) begin
      e_rb = nb; e_rr = nr; e_tw = nt;
    end
    hist_v.push_back(e_rv);
    hist_b.push_back(e_rb);
    hist_r.push_back(e_rr);
    sz = hist_v.size();
    ev = 0; eb = 0; er = 0;
    if (sz > LAT) begin
      ev = hist_v[sz-1-LAT];
      eb = hist_b[sz-1-LAT];
      er = hist_r[sz-1-LAT];
    end
    chk("rd_valid", rd_valid, e_rv);
    chk("rd_bank", rd_bank, e_rb);
    chk("rd_row", rd_row, e_rr);
    chk("tw_addr", tw_addr, e_tw);
    chk("wr_valid", wr_valid, ev);
    chk("wr_bank", wr_bank, eb);
    chk("wr_row", wr_row, er);
    chk("p_err", p_err, e_perr);
    if (sweep_on) begin
      if (wr_valid) begin
        wr_hi++;
        banks.push_back(wr_bank);
      end
      if (prev_rv && !rd_valid) rd_fall = cyc_no;
      if (prev_wv && !wr_valid) wr_fall = cyc_no;
    end
    prev_rv = rd_valid;
    prev_wv = wr_valid;
  endtask

  task automatic issue(input int pp, input int kk,
                       input int jj, input int ss);
    ren = 1'b1; p = 3'(pp); k = 8'(kk);
    j = 8'(jj); sel = ss[0];
    cyc();
  endtask

  task automatic idle(input int n);
    ren = 1'b0;
    for (int c = 0; c < n; c++) cyc();
  endtask

  task automatic rand_run(input int n, input int pmax);
    for (int c = 0; c < n; c++) begin
      ren = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 1);
      k = 8'($urandom_range(0, 255));
      j = 8'($urandom_range(0, 255));
      p = 3'($urandom_range(0, pmax));
      cyc();
    end
  endtask

  task automatic chk_rd(input string tag, input int b,
                        input int r, input int t);
    chk({tag, "_bank"}, rd_bank, b);
    chk({tag, "_row"}, rd_row, r);
    chk({tag, "_tw"}, tw_addr, t);
  endtask

  initial begin
    int bad_grp, wcnt;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_p_err", p_err, 0);
    chk("rst_tw", tw_addr, 0);
    rst = 1'b1;

    // test 1
    issue(1, 3, 1, 0);
    chk_rd("t1", 0, 13, 64);
    chk("t1_rv", rd_valid, 1);
    idle(LAT);
    chk("t1_wv", wr_valid, 1);
    chk("t1_wb", wr_bank, 0);
    chk("t1_wr", wr_row, 13);

    // tests 2 and 3, back to back
    issue(1, 3, 2, 1);
    chk_rd("t2a", 1, 14, 128);
    issue(4, 0, 200, 1);
    chk_rd("t2b", 1, 50, 56);
    issue(0, 255, 0, 0);
    chk_rd("t3a", 0, 63, 0);
    issue(2, 1, 5, 0);
    chk_rd("t3b", 3, 20, 80);
    idle(2);

    rand_run(1500, 4);
    idle(LAT + 2);

    // test 4: full sweep
    sweep_on = 1;
    for (int pe = 0; pe < 5; pe++)
      for (int i = 0; i < 256; i++) begin
        if (pe == 4) issue(4, 0, i, 0);
        else issue(pe, i >> (2 * pe),
                   i % (1 << (2 * pe)), 0);
      end
    idle(LAT + 4);
    sweep_on = 0;
    bad_grp = 0;
    for (int g = 0; g + 3 < banks.size(); g += 4)
      for (int a = 0; a < 4; a++)
        for (int b = a + 1; b < 4; b++)
          if (banks[g+a] == banks[g+b]) bad_grp++;
    chk("sweep_conflicts", bad_grp, 0);
    chk("sweep_wr_count", wr_hi, 1280);
    chk("sweep_lag", wr_fall - rd_fall, LAT);

    // test 5: bubbles and illegal stage
    issue(1, 3, 1, 0);
    ren = 1'b0; p = 3'd6; cyc();
    issue(1, 3, 2, 0);
    chk("t5_perr_lo", p_err, 0);
    issue(6, 3, 1, 0);
    chk("t5_perr_hi", p_err, 1);
    chk_rd("t5_pe0", 3, 0, 0);
    idle(LAT - 3);
    chk("t5_w0", wr_valid, 1);
    idle(1);
    chk("t5_w1", wr_valid, 0);
    idle(1);
    chk("t5_w2", wr_valid, 1);
    idle(1);
    chk("t5_w3", wr_valid, 1);
    idle(1);
    chk("t5_w4", wr_valid, 0);
    chk("t5_sticky", p_err, 1);

    rand_run(500, 7);

    // test 6: reset mid-flight
    for (int c = 0; c < 5; c++)
      issue(1, c, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("t6_rd_valid", rd_valid, 0);
    chk("t6_rd_bank", rd_bank, 0);
    chk("t6_rd_row", rd_row, 0);
    chk("t6_tw", tw_addr, 0);
    chk("t6_wr_valid", wr_valid, 0);
    chk("t6_wr_bank", wr_bank, 0);
    chk("t6_wr_row", wr_row, 0);
    chk("t6_p_err", p_err, 0);
    ren = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    wcnt = 0;
    for (int c = 0; c < LAT + 8; c++) begin
      cyc();
      if (wr_valid) wcnt++;
    end
    chk("t6_no_stale_wr", wcnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
